// File: rtl/win7_frame_scheduler_pkg.sv
// Shared constants, FSM state type and counter-width helper for the 7x7 frame scheduler.
package win7_pkg;

    localparam int K    = 7;
    localparam int HALO = 3;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH,
        DONE
    } state_e;

    function automatic int win7_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/win7_frame_scheduler_if.sv
// Column-stream and window handshake bundle between line buffers, scheduler and filter.
interface win7_frame_scheduler_if #(
    parameter int RW = 8,
    parameter int CW = 8
);
    logic          start_i;
    logic          valid_i;
    logic          ready_o;
    logic          shift_en_o;
    logic          win_valid_o;
    logic          win_ready_i;
    logic [RW-1:0] row_o;
    logic [CW-1:0] col_o;
    logic          busy_o;
    logic          done_o;

    modport master (
        output start_i, valid_i, win_ready_i,
        input  ready_o, shift_en_o, win_valid_o, row_o, col_o, busy_o, done_o
    );

    modport slave (
        input  start_i, valid_i, win_ready_i,
        output ready_o, shift_en_o, win_valid_o, row_o, col_o, busy_o, done_o
    );
endinterface

// File: rtl/win7_frame_scheduler_raster_counter.sv
// Raster position counters: advance on enable, wrap columns into rows, flag the last pixel.
module win7_raster_counter #(
    parameter int ROWS = 256,
    parameter int COLS = 256,
    parameter int RW   = 8,
    parameter int CW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [RW-1:0] r_o,
    output logic [CW-1:0] c_o,
    output logic          last_o
);
    logic [RW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;

    always_comb begin
        r_d = r_q;
        c_d = c_q;
        if (clr_i) begin
            r_d = '0;
            c_d = '0;
        end else if (en_i) begin
            if (c_q == CW'(COLS - 1)) begin
                c_d = '0;
                // Row saturates at the bottom edge; the FSM stops accepting there anyway.
                if (r_q != RW'(ROWS - 1)) r_d = r_q + RW'(1);
            end else begin
                c_d = c_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
            c_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
        end
    end

    assign r_o    = r_q;
    assign c_o    = c_q;
    assign last_o = (r_q == RW'(ROWS - 1)) && (c_q == CW'(COLS - 1));
endmodule

// File: rtl/win7_frame_scheduler.sv
// Frame scheduler for the 7x7 window path: FSM, window handshake and shift enable.
// Optional stall-cycle counter output enabled by defining WIN7_STALL_CNT_EN.
module win7_frame_scheduler
    import win7_pkg::*;
#(
    parameter int ROWS = 256,
    parameter int COLS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    win7_frame_scheduler_if.slave bus
`ifdef WIN7_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt_o
`endif
);
    localparam int RW = win7_cnt_w(ROWS);
    localparam int CW = win7_cnt_w(COLS);

    if (ROWS < K || COLS < K) begin : g_bad_dims
        $error("win7_frame_scheduler: ROWS and COLS must both be at least 7");
    end

    state_e        state_q;
    logic          win_valid_q, busy_q, done_q;
    logic [RW-1:0] row_q, r;
    logic [CW-1:0] col_q, c;
    logic          ready, accept, win_set, last, clr;

    assign ready   = ((state_q == FILL) || (state_q == RUN)) && (!win_valid_q || bus.win_ready_i);
    assign accept  = bus.valid_i && ready;
    assign win_set = accept && (r >= RW'(K - 1)) && (c >= CW'(K - 1));
    assign clr     = (state_q == IDLE) && bus.start_i;

    win7_raster_counter #(
        .ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .en_i   (accept),
        .r_o    (r),
        .c_o    (c),
        .last_o (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            win_valid_q <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // A new window overrides the consume so back-to-back windows need no bubble.
            if (win_set) begin
                win_valid_q <= 1'b1;
                row_q       <= r - RW'(HALO);
                col_q       <= c - CW'(HALO);
            end else if (bus.win_ready_i) begin
                win_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: if (bus.start_i) begin
                    state_q <= FILL;
                    busy_q  <= 1'b1;
                end
                FILL: if (accept && (r == RW'(K - 1)) && (c == '0)) state_q <= RUN;
                RUN:  if (accept && last) state_q <= FLUSH;
                FLUSH: if (win_valid_q && bus.win_ready_i) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready_o     = ready;
    assign bus.shift_en_o  = accept;
    assign bus.win_valid_o = win_valid_q;
    assign bus.row_o       = row_q;
    assign bus.col_o       = col_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;

`ifdef WIN7_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (clr) begin
            stall_cnt_q <= '0;
        end else if (win_valid_q && !bus.win_ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_win7_frame_scheduler.sv
// Randomized scoreboard bench for win7_frame_scheduler on an 8x8 frame.
module tb_win7_frame_scheduler;
    import win7_pkg::*;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int RW   = win7_cnt_w(ROWS);
    localparam int CW   = win7_cnt_w(COLS);
    localparam int NWIN = (ROWS - 6) * (COLS - 6);

    typedef struct {
        int r;
        int c;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    win7_frame_scheduler_if #(.RW(RW), .CW(CW)) bus ();
`ifdef WIN7_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    win7_frame_scheduler #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef WIN7_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    int   total = 0, bad = 0;
    int   cyc = 0, acc_cnt = 0, win_cnt = 0, done_cnt = 0, last_hs = -10;
    win_t exp_q[$];
    bit   hold_v = 0, busy_pend = 0;
    int   hold_r, hold_c;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, between stimulus updates.
    always @(negedge clk) begin
        if (!rst) begin
            hold_v    = 0;
            busy_pend = 0;
        end else begin
            chk("shift_en_eq", bus.shift_en_o, bus.valid_i & bus.ready_o);
            if (bus.shift_en_o) acc_cnt++;
            if (hold_v) begin
                chk("hold_valid", bus.win_valid_o, 1);
                chk("hold_row", bus.row_o, hold_r);
                chk("hold_col", bus.col_o, hold_c);
            end
            hold_v = 0;
            if (bus.win_valid_o && !bus.win_ready_i) begin
                chk("stall_ready", bus.ready_o, 0);
                hold_v = 1;
                hold_r = bus.row_o;
                hold_c = bus.col_o;
            end
            if (bus.win_valid_o && bus.win_ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL win_unexpected: got row %0d col %0d expected none", bus.row_o, bus.col_o);
                end else begin
                    win_t e;
                    e = exp_q.pop_front();
                    chk("win_row", bus.row_o, e.r);
                    chk("win_col", bus.col_o, e.c);
                    win_cnt++;
                    if (exp_q.size() == 0) last_hs = cyc;
                end
            end
            if (busy_pend) begin
                chk("busy_after_done", bus.busy_o, 0);
                busy_pend = 0;
            end
            if (bus.done_o) begin
                done_cnt++;
                chk("done_latency", cyc, last_hs + 1);
                busy_pend = 1;
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, bus.ready_o, 0);
        chk({tag, "_shift"}, bus.shift_en_o, 0);
        chk({tag, "_wvalid"}, bus.win_valid_o, 0);
        chk({tag, "_row"}, bus.row_o, 0);
        chk({tag, "_col"}, bus.col_o, 0);
        chk({tag, "_busy"}, bus.busy_o, 0);
        chk({tag, "_done"}, bus.done_o, 0);
`ifdef WIN7_STALL_CNT_EN
        chk({tag, "_stall"}, stall_cnt, 0);
`endif
    endtask

    task automatic pulse_start();
        bus.valid_i = 0;
        bus.start_i = 1;
        @(posedge clk); #1;
        bus.start_i = 0;
        chk("start_busy", bus.busy_o, 1);
        chk("start_ready", bus.ready_o, 1);
    endtask

    task automatic run_frame(input int vpct, input int rpct, input bit tog, input bit noise, input bit bp);
        int a0, w0, d0, n;
        bit bp_done;
        bp_done = 0;
        n = 0;
        for (int r = K - 1; r < ROWS; r++)
            for (int c = K - 1; c < COLS; c++)
                exp_q.push_back('{r: r - HALO, c: c - HALO});
        a0 = acc_cnt; w0 = win_cnt; d0 = done_cnt;
        pulse_start();
        while (done_cnt == d0 && n < 2000) begin
            if (bp && !bp_done && bus.win_valid_o) begin
                bus.win_ready_i = 0;
                bus.valid_i = 1;
                for (int i = 0; i < 5; i++) begin
                    #1;
                    chk("bp_ready", bus.ready_o, 0);
                    chk("bp_shift", bus.shift_en_o, 0);
                    chk("bp_row", bus.row_o, 3);
                    chk("bp_col", bus.col_o, 3);
                    @(posedge clk); #1;
                end
                bp_done = 1;
            end
            bus.valid_i     = tog ? (n % 2 == 0) : ($urandom_range(99) < vpct);
            bus.win_ready_i = bp ? 1'b1 : ($urandom_range(99) < rpct);
            if (noise) bus.start_i = ($urandom_range(7) == 0);
            @(posedge clk); #1;
            n++;
        end
        bus.valid_i = 0;
        bus.start_i = 0;
        bus.win_ready_i = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("frame_timeout", n < 2000, 1);
        chk("frame_accepts", acc_cnt - a0, ROWS * COLS);
        chk("frame_windows", win_cnt - w0, NWIN);
        chk("frame_dones", done_cnt - d0, 1);
        chk("frame_queue_left", exp_q.size(), 0);
        chk("frame_idle_busy", bus.busy_o, 0);
`ifdef WIN7_STALL_CNT_EN
        if (bp) chk("bp_stall_cnt", stall_cnt, 5);
`endif
    endtask

    initial begin
        int a0, n;
        bus.start_i = 0;
        bus.valid_i = 1;
        bus.win_ready_i = 1;
        #12;
        check_zero("rst_init");
        @(negedge clk) rst = 1;
        bus.valid_i = 0;
        @(posedge clk); #1;

        // valid_i in IDLE must be ignored.
        for (int i = 0; i < 5; i++) begin
            bus.valid_i = 1;
            bus.win_ready_i = $urandom_range(1);
            #1;
            chk("idle_shift", bus.shift_en_o, 0);
            chk("idle_ready", bus.ready_o, 0);
            @(posedge clk); #1;
        end
        chk("idle_done", done_cnt, 0);

        run_frame(100, 100, 0, 0, 0);   // nominal
        run_frame(100, 100, 0, 0, 1);   // backpressure at first window
        run_frame(0, 100, 1, 0, 0);     // valid_i toggling
        for (int k = 0; k < 4; k++)
            run_frame($urandom_range(40, 100), $urandom_range(30, 100), 0, 1, 0);

        // Reset mid-frame after 30 accepts (still inside FILL, no windows yet).
        a0 = acc_cnt;
        n = 0;
        pulse_start();
        bus.win_ready_i = 1;
        while (acc_cnt - a0 < 30 && n < 200) begin
            bus.valid_i = 1;
            @(posedge clk); #1;
            n++;
        end
        chk("mid_timeout", n < 200, 1);
        #2;
        rst = 0;
        bus.valid_i = $urandom_range(1);
        bus.win_ready_i = $urandom_range(1);
        bus.start_i = $urandom_range(1);
        #1;
        check_zero("rst_mid");
        exp_q.delete();
        repeat (2) @(posedge clk);
        bus.start_i = 0;
        bus.valid_i = 0;
        bus.win_ready_i = 1;
        @(negedge clk) rst = 1;
        @(posedge clk); #1;
        chk("rst_rel_busy", bus.busy_o, 0);
        chk("rst_rel_ready", bus.ready_o, 0);
        run_frame(100, 100, 0, 0, 0);
        run_frame(70, 60, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
